vgafb_pixelsink: RTL and testbench
==================================

Name: vgafb_pixelsink

Overview:
- FML write master: the reverse of the framebuffer pixel feed.
- Accepts a 16-bit RGB565 pixel stream (valid/ack) from a capture or render source.
- Packs pixel pairs into 32-bit words and buffers them in a small FIFO.
- Writes words to SDRAM through single-word FML write transactions, walking a frame of nwords words from baseaddress and wrapping at frame end.

Parameters:
- FIFO_DEPTH_LOG2, 3, log2 of packed-word FIFO depth (8 x 32-bit words).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset; aborts everything, including a pending FML write.
- enable  in  1  synchronous run control; low = idle/flush, but never aborts a pending FML write.
- nwords  in  19  words per frame; 0 is treated as 1.
- baseaddress  in  32  frame start byte address; bits [1:0] ignored.
- baseaddress_ack  out  1  one-cycle pulse when baseaddress is sampled for a new frame.
- frame_done  out  1  one-cycle pulse on the ack of the last word of a frame.
- pixel_valid  in  1  source has a pixel.
- pixel  in  16  pixel data.
- pixel_ack  out  1  pixel consumed this cycle.
- fml_adr  out  32  word address, bits [1:0] = 0.
- fml_stb  out  1  request strobe.
- fml_we  out  1  write enable; equals fml_stb.
- fml_sel  out  4  byte enables; always 4'hF.
- fml_do  out  32  write data.
- fml_ack  in  1  one-cycle transfer acknowledge.

Behaviour:
- Reset values:
  - fml_stb=0, fml_we=0, fml_adr=0, fml_do=0, baseaddress_ack=0, frame_done=0.
  - FIFO empty, packer half-flag=0, wcounter=1.
- pixel_ack is combinational: pixel_valid & enable & ~fifo_full. fifo_full is taken from the registered word count.
- Packer:
  - First accepted pixel latches into bits [31:16].
  - Second accepted pixel forms the word {first, second}, pushed into the FIFO on the next clock edge.
  - Half-flag toggles on each accept.
- FSM, two states:
  - IDLE: fml_stb=0. If enable and FIFO non-empty, load fml_do from the FIFO head, pop it, set fml_stb=1, go to REQ. Requests start no earlier than the cycle after the word enters the FIFO.
  - REQ: hold fml_stb/fml_adr/fml_do stable until fml_ack. On fml_ack: clear fml_stb, go to IDLE. Minimum one idle cycle between transfers.
  - Latency: pixel pair accepted at cycle N -> fml_stb high at cycle N+2 (FIFO empty, IDLE).
- Address generation, evaluated on each fml_ack:
  - If wcounter == max(nwords,1): wcounter<=1, fml_adr<={baseaddress[31:2],2'b00}, baseaddress_ack and frame_done pulse.
  - Else: wcounter+1, fml_adr+4. 32-bit wrap is silent.
- When enable=0 and FSM in IDLE:
  - fml_adr tracks baseaddress and wcounter=1.
  - baseaddress_ack pulses on the cycle enable rises.
- Disable mid-operation:
  - The half-packed pixel is dropped and the FIFO is flushed immediately.
  - An in-flight REQ completes normally, including the address advance. The address then reloads from baseaddress once IDLE.
- Simultaneous push and pop in one cycle: both allowed, count unchanged.
- No push when full: backpressure only, no overflow is possible.
- sys_rst asserted during REQ: fml_stb drops immediately and asynchronously.

Test Plan:
- Enable with baseaddress=0x00100000, nwords=4; feed pixels 0x1111,0x2222,...,0x8888 back-to-back; slave acks 1 cycle after stb -> writes 0x11112222@0x100000, 0x33334444@0x100004, 0x55556666@0x100008, 0x77778888@0x10000C; frame_done on 4th ack; next fml_adr=0x100000.
- Slave never acks; stream 20 pixels -> fml_stb held with constant adr/do; pixel_ack drops after FIFO holds 8 words plus 1 in REQ (18 pixels accepted); ack resumes -> all 9 words written in order.
- Feed 3 pixels then drop enable while a write is pending -> pending write completes; 3rd pixel is discarded; no further stb; re-enable -> baseaddress_ack pulse; first write goes to baseaddress.
- nwords=0 -> every ack wraps; all writes go to baseaddress and frame_done pulses every word.
- Change baseaddress to 0x00200000 mid-frame with nwords=2 -> current frame finishes at old addresses; next frame starts at 0x200000.
- Assert sys_rst while fml_stb=1 -> fml_stb=0 asynchronously; all outputs at reset values; FIFO empty.

Source files
------------

// File: rtl/vgafb_pixelsink_if.sv
// Pixel stream and FML write bus of the framebuffer pixel sink.
//
// Handshake rules:
//   pixel stream: the source holds pixel_valid and pixel stable until it
//   sees pixel_ack. A pixel is consumed in every cycle where pixel_valid and
//   pixel_ack are both high. pixel_ack may depend combinationally on
//   pixel_valid.
//   FML: the master raises fml_stb (with fml_we) and holds fml_adr/fml_do
//   stable until the slave returns a one-cycle fml_ack. The transfer
//   completes on that ack, and the master drops fml_stb in the next cycle.
interface vgafb_pixelsink_if;
  logic        pixel_valid;
  logic [15:0] pixel;
  logic        pixel_ack;
  logic [31:0] fml_adr;
  logic        fml_stb;
  logic        fml_we;
  logic [3:0]  fml_sel;
  logic [31:0] fml_do;
  logic        fml_ack;

  // The pixel sink: consumes pixels and masters the FML bus.
  modport master (
    input  pixel_valid, pixel, fml_ack,
    output pixel_ack, fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );

  // The environment: the pixel source and the FML slave.
  modport slave (
    output pixel_valid, pixel, fml_ack,
    input  pixel_ack, fml_adr, fml_stb, fml_we, fml_sel, fml_do
  );
endinterface

// File: rtl/vgafb_pixelsink.sv
// Framebuffer pixel sink: packs RGB565 pixel pairs into 32-bit words,
// buffers them in a small FIFO and writes them one word at a time over FML,
// walking a frame of nwords words from baseaddress and wrapping at the end.
module vgafb_pixelsink #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [18:0] nwords,
  input  logic [31:0] baseaddress,
  output logic        baseaddress_ack,
  output logic        frame_done,
  output logic [0:0]  dbg_state,
  vgafb_pixelsink_if.master bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE    = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Packer and FIFO
  logic [31:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       half_q;
  logic [15:0]                hi_q;

  // Write engine
  logic [0:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] do_q, do_d;
  logic [18:0] wcounter_q, wcounter_d;
  logic        armed_q, armed_d;
  logic        ba_q, ba_d;
  logic        fd_q, fd_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_word;
  logic [31:0] base_word;
  logic [18:0] nwords_eff;
  logic        unused_base_bits;

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign accept     = bus.pixel_valid & enable & ~fifo_full;
  // The second pixel of a pair completes a word that is written this edge.
  assign push       = accept & half_q;
  assign push_word  = {hi_q, bus.pixel};
  assign base_word  = {baseaddress[31:2], 2'b00};
  assign nwords_eff = (nwords == 19'd0) ? 19'd1 : nwords;
  assign unused_base_bits = ^baseaddress[1:0];

  // Pack pixel pairs and keep FIFO pointers; disabling drops everything.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
      hi_q     <= '0;
    end else if (!enable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
    end else begin
      if (accept) begin
        half_q <= ~half_q;
        if (!half_q) hi_q <= bus.pixel;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count_q guards reads.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  // Next-state logic: start a write from the FIFO head, wait for the ack,
  // advance or wrap the frame position. armed_q records that baseaddress
  // has been sampled since the last time enable was low.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    do_d       = do_q;
    wcounter_d = wcounter_q;
    armed_d    = armed_q & enable;
    ba_d       = 1'b0;
    fd_d       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!enable) begin
          adr_d      = base_word;
          wcounter_d = 19'd1;
        end else if (!armed_q) begin
          adr_d      = base_word;
          wcounter_d = 19'd1;
          armed_d    = 1'b1;
          ba_d       = 1'b1;
        end else if (!fifo_empty) begin
          do_d    = mem_q[rd_ptr_q];
          pop     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.fml_ack) begin
          state_d = S_IDLE;
          if (wcounter_q == nwords_eff) begin
            wcounter_d = 19'd1;
            adr_d      = base_word;
            ba_d       = 1'b1;
            fd_d       = 1'b1;
          end else begin
            wcounter_d = wcounter_q + 19'd1;
            adr_d      = adr_q + 32'd4;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write engine registers; reset drops a pending strobe asynchronously.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      do_q       <= '0;
      wcounter_q <= 19'd1;
      armed_q    <= 1'b0;
      ba_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      do_q       <= do_d;
      wcounter_q <= wcounter_d;
      armed_q    <= armed_d;
      ba_q       <= ba_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.pixel_ack   = accept;
  assign bus.fml_stb     = (state_q == S_REQ);
  assign bus.fml_we      = (state_q == S_REQ);
  assign bus.fml_sel     = 4'hF;
  assign bus.fml_adr     = adr_q;
  assign bus.fml_do      = do_q;
  assign baseaddress_ack = ba_q;
  assign frame_done      = fd_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_vgafb_pixelsink.sv
// Bench for vgafb_pixelsink: directed scenarios plus a randomized phase,
// checked every cycle against a queue-based behavioural model.
module tb_vgafb_pixelsink;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [18:0] nwords;
  logic [31:0] baseaddress;
  logic        baseaddress_ack;
  logic        frame_done;
  logic [0:0]  dbg_state;

  vgafb_pixelsink_if bus();

  vgafb_pixelsink #(.FIFO_DEPTH_LOG2(3)) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .enable          (enable),
    .nwords          (nwords),
    .baseaddress     (baseaddress),
    .baseaddress_ack (baseaddress_ack),
    .frame_done      (frame_done),
    .dbg_state       (dbg_state),
    .bus             (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  int ba_count = 0;
  int fd_count = 0;
  logic [63:0] wr_log[$];   // {adr, data} of every acked write
  bit ack_stall = 0;
  int ack_delay = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected FIFO contents as a queue of packed words; the frame position is
  // a plain word index into the frame starting at m_base.
  logic [31:0] exp_q[$];
  bit          m_busy, m_half, m_armed, m_ba, m_fd;
  logic [15:0] m_hi;
  logic [31:0] m_do, m_base;
  int unsigned m_idx;

  function automatic logic [31:0] m_adr();
    return m_base + 32'(m_idx) * 32'd4;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      exp_q.delete();
      m_busy = 0; m_half = 0; m_armed = 0; m_ba = 0; m_fd = 0;
      m_hi = '0; m_do = '0; m_base = '0; m_idx = 0;
    end else begin
      bit acc;
      int unsigned nw;
      logic [31:0] base_al;
      acc     = bus.pixel_valid && enable && (exp_q.size() < 8);
      nw      = (nwords == 0) ? 1 : int'(nwords);
      base_al = {baseaddress[31:2], 2'b00};
      m_ba = 0;
      m_fd = 0;
      if (m_busy) begin
        if (bus.fml_ack) begin
          m_busy = 0;
          m_idx++;
          if (m_idx == nw) begin
            m_idx = 0; m_base = base_al; m_ba = 1; m_fd = 1;
          end
        end
      end else if (!enable) begin
        m_base = base_al; m_idx = 0;
      end else if (!m_armed) begin
        m_base = base_al; m_idx = 0; m_armed = 1; m_ba = 1;
      end else if (exp_q.size() > 0) begin
        m_do = exp_q.pop_front();
        m_busy = 1;
      end
      if (!enable) begin
        exp_q.delete(); m_half = 0; m_armed = 0;
      end else if (acc) begin
        if (m_half) exp_q.push_back({m_hi, bus.pixel});
        else m_hi = bus.pixel;
        m_half = !m_half;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    if (check_en && !sys_rst) begin
      check("fml_stb", {31'd0, bus.fml_stb}, {31'd0, m_busy});
      check("fml_we", {31'd0, bus.fml_we}, {31'd0, m_busy});
      check("fml_sel", {28'd0, bus.fml_sel}, 32'h0000000F);
      check("fml_adr", bus.fml_adr, m_adr());
      check("fml_do", bus.fml_do, m_do);
      check("pixel_ack", {31'd0, bus.pixel_ack},
            {31'd0, bus.pixel_valid && enable && (exp_q.size() < 8)});
      check("baseaddress_ack", {31'd0, baseaddress_ack}, {31'd0, m_ba});
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      check("dbg_state", {31'd0, dbg_state}, {31'd0, m_busy});
      if (baseaddress_ack) ba_count++;
      if (frame_done) fd_count++;
    end
  end

  // Write log of acknowledged transfers.
  always @(posedge sys_clk) begin
    if (!sys_rst && bus.fml_stb && bus.fml_ack) wr_log.push_back({bus.fml_adr, bus.fml_do});
  end

  // ---------------- FML slave ----------------
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.fml_ack = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!bus.fml_stb) begin
        bus.fml_ack = 1'b0;
        wait_cnt = 0;
      end else if (ack_stall) begin
        bus.fml_ack = 1'b0;
      end else begin
        bus.fml_ack = (wait_cnt >= ack_delay);
        wait_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_pixel(input logic [15:0] v, input int budget, output bit ok);
    bus.pixel_valid = 1'b1;
    bus.pixel = v;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk);
      ok = bus.pixel_ack;
      @(posedge sys_clk);
      #1;
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [15:0] v);
    bit ok;
    send_pixel(v, 200, ok);
    check("pixel_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    int q;
    q = 0;
    for (int i = 0; i < 500 && q < 4; i++) begin
      tick(1);
      q = bus.fml_stb ? 0 : q + 1;
    end
    check("idle_timeout", {31'd0, q >= 4}, 32'd1);
  endtask

  task automatic check_write(input string name, input int idx, input logic [31:0] adr,
                             input logic [31:0] data);
    if (idx < wr_log.size()) begin
      check({name, "_adr"}, wr_log[idx][63:32], adr);
      check({name, "_data"}, wr_log[idx][31:0], data);
    end else begin
      check({name, "_missing"}, 32'(wr_log.size()), 32'(idx + 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start, fd0, ba0, acc_n;
    bit ok;

    sys_rst = 1'b1;
    enable = 1'b0;
    nwords = 19'd4;
    baseaddress = 32'h0010_0000;
    bus.pixel_valid = 1'b1;
    bus.pixel = 16'h0;
    tick(3);
    // Reset values
    check("rst_stb", {31'd0, bus.fml_stb}, 32'd0);
    check("rst_we", {31'd0, bus.fml_we}, 32'd0);
    check("rst_adr", bus.fml_adr, 32'd0);
    check("rst_do", bus.fml_do, 32'd0);
    check("rst_ba", {31'd0, baseaddress_ack}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    check("rst_pixel_ack", {31'd0, bus.pixel_ack}, 32'd0);
    bus.pixel_valid = 1'b0;
    sys_rst = 1'b0;
    check_en = 1;
    tick(2);

    // 1: basic frame of 4 words, ack one cycle after stb
    enable = 1'b1;
    tick(2);
    start = wr_log.size();
    fd0 = fd_count;
    for (int k = 1; k <= 8; k++) send_chk(16'(32'h1111 * k));
    wait_idle();
    check_write("t1_w0", start + 0, 32'h0010_0000, 32'h1111_2222);
    check_write("t1_w1", start + 1, 32'h0010_0004, 32'h3333_4444);
    check_write("t1_w2", start + 2, 32'h0010_0008, 32'h5555_6666);
    check_write("t1_w3", start + 3, 32'h0010_000C, 32'h7777_8888);
    check("t1_frame_done", 32'(fd_count - fd0), 32'd1);
    check("t1_next_adr", bus.fml_adr, 32'h0010_0000);

    // 2: slave stalls; FIFO fills to 8 words plus one in flight
    ack_stall = 1;
    start = wr_log.size();
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      send_pixel(16'(32'hA000 + i), 20, ok);
      if (!ok) break;
      acc_n++;
    end
    check("t2_accepted", 32'(acc_n), 32'd18);
    check("t2_stb_held", {31'd0, bus.fml_stb}, 32'd1);
    check("t2_adr_held", bus.fml_adr, 32'h0010_0000);
    check("t2_do_held", bus.fml_do, 32'hA000_A001);
    ack_stall = 0;
    for (int i = acc_n; i < 20; i++) send_chk(16'(32'hA000 + i));
    wait_idle();
    for (int j = 0; j < 10; j++)
      check_write("t2_w", start + j, 32'h0010_0000 + 32'(4 * (j % 4)),
                  {16'(32'hA000 + 2 * j), 16'(32'hA000 + 2 * j + 1)});

    // 3: disable with a write pending, then re-enable at a new base
    ack_delay = 5;
    start = wr_log.size();
    send_chk(16'hC001);
    send_chk(16'hC002);
    check("t3_latency_n1", {31'd0, bus.fml_stb}, 32'd0);
    send_chk(16'hC003);
    check("t3_latency_n2", {31'd0, bus.fml_stb}, 32'd1);
    enable = 1'b0;
    wait_idle();
    check("t3_pending_done", 32'(wr_log.size() - start), 32'd1);
    check_write("t3_pending", start, 32'h0010_0008, 32'hC001_C002);
    baseaddress = 32'h0030_0003;
    tick(10);
    check("t3_no_stb", 32'(wr_log.size() - start), 32'd1);
    ba0 = ba_count;
    enable = 1'b1;
    tick(3);
    check("t3_ba_pulse", 32'(ba_count - ba0), 32'd1);
    send_chk(16'hC004);
    send_chk(16'hC005);
    wait_idle();
    check_write("t3_first", start + 1, 32'h0030_0000, 32'hC004_C005);

    // 4: nwords = 0 behaves as one word per frame
    ack_delay = 0;
    enable = 1'b0;
    nwords = 19'd0;
    baseaddress = 32'h0040_0000;
    tick(2);
    enable = 1'b1;
    tick(2);
    start = wr_log.size();
    fd0 = fd_count;
    for (int k = 0; k < 6; k++) send_chk(16'(32'hD000 + k));
    wait_idle();
    for (int j = 0; j < 3; j++)
      check_write("t4_w", start + j, 32'h0040_0000,
                  {16'(32'hD000 + 2 * j), 16'(32'hD000 + 2 * j + 1)});
    check("t4_frame_done", 32'(fd_count - fd0), 32'd3);

    // 5: base changes mid-frame; takes effect at the next frame
    ack_delay = 2;
    enable = 1'b0;
    nwords = 19'd2;
    baseaddress = 32'h0010_0000;
    tick(2);
    enable = 1'b1;
    tick(2);
    start = wr_log.size();
    send_chk(16'hE000);
    send_chk(16'hE001);
    wait_idle();
    baseaddress = 32'h0020_0000;
    for (int k = 2; k < 8; k++) send_chk(16'(32'hE000 + k));
    wait_idle();
    check_write("t5_w0", start + 0, 32'h0010_0000, 32'hE000_E001);
    check_write("t5_w1", start + 1, 32'h0010_0004, 32'hE002_E003);
    check_write("t5_w2", start + 2, 32'h0020_0000, 32'hE004_E005);
    check_write("t5_w3", start + 3, 32'h0020_0004, 32'hE006_E007);

    // 6: asynchronous reset while a write is pending
    ack_stall = 1;
    for (int k = 0; k < 4; k++) send_chk(16'(32'hF000 + k));
    tick(2);
    check("t6_stb_before", {31'd0, bus.fml_stb}, 32'd1);
    start = wr_log.size();
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    check("t6_async_stb", {31'd0, bus.fml_stb}, 32'd0);
    check("t6_async_we", {31'd0, bus.fml_we}, 32'd0);
    check("t6_async_adr", bus.fml_adr, 32'd0);
    check("t6_async_do", bus.fml_do, 32'd0);
    check("t6_async_ba", {31'd0, baseaddress_ack}, 32'd0);
    check("t6_async_fd", {31'd0, frame_done}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    ack_stall = 0;
    tick(10);
    check("t6_fifo_empty", 32'(wr_log.size() - start), 32'd0);
    check("t6_stb_idle", {31'd0, bus.fml_stb}, 32'd0);

    // 7: randomized segments, including abrupt disables
    for (int seg = 0; seg < 40; seg++) begin
      bit acc;
      enable = 1'b0;
      tick($urandom_range(1, 3));
      nwords = 19'($urandom_range(0, 5));
      baseaddress = $urandom;
      ack_delay = $urandom_range(0, 3);
      enable = 1'b1;
      bus.pixel_valid = ($urandom_range(0, 3) != 0);
      bus.pixel = 16'($urandom);
      for (int k = 0; k < int'($urandom_range(4, 40)); k++) begin
        @(negedge sys_clk);
        acc = bus.pixel_ack;
        @(posedge sys_clk);
        #1;
        if (acc || !bus.pixel_valid) begin
          bus.pixel_valid = ($urandom_range(0, 3) != 0);
          bus.pixel = 16'($urandom);
        end
      end
      bus.pixel_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    enable = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
